// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator: 720p defaults, pattern
// encodings and the colour-bar palette.
`timescale 1ns/1ps
package video_timing_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  // Bar 0 is leftmost: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [0:7][23:0] BAR_COLOURS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output bus from the timing generator towards the TMDS encoder stage.
`timescale 1ns/1ps
interface video_timing_gen_if;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [10:0] x;
  logic [9:0]  y;

  modport master (output hsync, vsync, active, frame_start, red, green, blue, x, y);
  modport slave  (input  hsync, vsync, active, frame_start, red, green, blue, x, y);
endinterface

// File: rtl/video_timing_gen_pattern.sv
// Combinational test-pattern generator: maps the selected pattern and the
// current counter position to a 24-bit {R,G,B} value.
`timescale 1ns/1ps
module pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P
) (
  input  pattern_e    pat_i,
  input  logic [23:0] solid_i,
  input  logic [10:0] h_i,
  input  logic        vTile_i,
  output logic [23:0] rgb_o
);

  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [10:0] barIdx;

  // Bars past index 7 only occur if H_ACTIVE is not a multiple of 8; clamp to black.
  always_comb begin
    barIdx = h_i / BAR_W;
    rgb_o  = '0;
    case (pat_i)
      PAT_BARS:    rgb_o = (barIdx > 11'd7) ? BAR_COLOURS[7] : BAR_COLOURS[barIdx[2:0]];
      PAT_RAMP:    rgb_o = {3{h_i[10:3]}};
      PAT_CHECKER: rgb_o = (h_i[5] ^ vTile_i) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID:   rgb_o = solid_i;
      default:     rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns; every output is
// registered one cycle after the counter position it describes.
`timescale 1ns/1ps
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   H_FP     = H_FP_720P,
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BP     = H_BP_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter int   V_FP     = V_FP_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BP     = V_BP_720P,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic               pixclk,
  input  logic               reset_n,
  input  logic [1:0]         pat_sel,
  input  logic [23:0]        solid_rgb,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        run_q;
  logic [10:0] hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  pattern_e    pat_q, pat_d;
  logic [23:0] solid_q, solid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        frameStart_q, frameStart_d;
  logic [23:0] rgb_q, rgb_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        atOrigin;
  logic [23:0] patRgb;

  pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .pat_i   (pat_d),
    .solid_i (solid_d),
    .h_i     (hCnt_q),
    .vTile_i (vCnt_q[5]),
    .rgb_o   (patRgb)
  );

  // run_q holds the counters at the origin for the first edge after reset so
  // the pattern select is captured before the first pixel is emitted. At the
  // origin the live select feeds the pattern so pixel (0,0) already uses it.
  always_comb begin
    atOrigin = (hCnt_q == '0) && (vCnt_q == '0);
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    if (run_q) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 11'd1;
      end
    end

    pat_d   = atOrigin ? pattern_e'(pat_sel) : pat_q;
    solid_d = atOrigin ? solid_rgb : solid_q;

    active_d     = run_q && (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
    hsync_d      = (run_q && hCnt_q >= HS_START && hCnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = (run_q && vCnt_q >= VS_START && vCnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    frameStart_d = run_q && atOrigin;
    rgb_d        = active_d ? patRgb : '0;
    x_d          = run_q ? hCnt_q : '0;
    y_d          = run_q ? vCnt_q : '0;
  end

  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      pat_q        <= PAT_BARS;
      solid_q      <= '0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      active_q     <= 1'b0;
      frameStart_q <= 1'b0;
      rgb_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      run_q        <= 1'b1;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      pat_q        <= pat_d;
      solid_q      <= solid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      frameStart_q <= frameStart_d;
      rgb_q        <= rgb_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.active      = active_q;
  assign vid.frame_start = frameStart_q;
  assign vid.red         = rgb_q[23:16];
  assign vid.green       = rgb_q[15:8];
  assign vid.blue        = rgb_q[7:0];
  assign vid.x           = x_q;
  assign vid.y           = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster: a pixel-index
// reference model predicts every output cycle, including mid-frame reset.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int   HA  = 64;
  localparam int   HFP = 4;
  localparam int   HSW = 6;
  localparam int   HBP = 10;
  localparam int   VA  = 40;
  localparam int   VFP = 2;
  localparam int   VSW = 3;
  localparam int   VBP = 5;
  localparam logic POL = 1'b0;
  localparam int   HT  = HA + HFP + HSW + HBP;
  localparam int   VT  = VA + VFP + VSW + VBP;
  localparam int   FT  = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  logic        pixclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;

  video_timing_gen_if vid();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(POL)
  ) dut (
    .pixclk    (pixclk),
    .reset_n   (reset_n),
    .pat_sel   (pat_sel),
    .solid_rgb (solid_rgb),
    .vid       (vid)
  );

  always #5 pixclk = ~pixclk;

  pix_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  bit          modelActive = 1'b0;
  logic [1:0]  framePat[8];
  logic [23:0] frameSolid[8];

  function automatic logic [23:0] refColour(logic [1:0] pat, logic [23:0] solid, int h, int v);
    logic [7:0] g;
    case (pat)
      2'd0: begin
        case (h / (HA / 8))
          0:       return 24'hFFFFFF;
          1:       return 24'hFFFF00;
          2:       return 24'h00FFFF;
          3:       return 24'h00FF00;
          4:       return 24'hFF00FF;
          5:       return 24'hFF0000;
          6:       return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd1: begin
        g = 8'((h / 8) % 256);
        return {g, g, g};
      end
      2'd2:    return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  // Edge kk after reset release; edge 1 still shows reset values, edge kk>=2
  // presents raster pixel kk-2.
  function automatic pix_t expectPix(int kk);
    pix_t e;
    int   p, h, v, f;
    e.hs  = ~POL;
    e.vs  = ~POL;
    e.act = 1'b0;
    e.fs  = 1'b0;
    e.x   = '0;
    e.y   = '0;
    e.rgb = '0;
    if (kk >= 2) begin
      p = kk - 2;
      h = p % HT;
      v = (p / HT) % VT;
      f = p / FT;
      e.act = (h < HA) && (v < VA);
      e.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? POL : ~POL;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? POL : ~POL;
      e.fs  = (h == 0) && (v == 0);
      e.x   = 11'(h);
      e.y   = 10'(v);
      e.rgb = e.act ? refColour(framePat[f], frameSolid[f], h, v) : 24'h0;
    end
    return e;
  endfunction

  function automatic pix_t sampleDut();
    return {vid.hsync, vid.vsync, vid.active, vid.frame_start,
            vid.x, vid.y, vid.red, vid.green, vid.blue};
  endfunction

  task automatic checkOutput(string name, pix_t got, pix_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got hs=%b vs=%b act=%b fs=%b x=%0d y=%0d rgb=%h, want hs=%b vs=%b act=%b fs=%b x=%0d y=%0d rgb=%h",
               name, got.hs, got.vs, got.act, got.fs, got.x, got.y, got.rgb,
               want.hs, want.vs, want.act, want.fs, want.x, want.y, want.rgb);
    end
  endtask

  task automatic checkValue(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(logic [1:0] sel, logic [23:0] solid);
    pat_sel   = sel;
    solid_rgb = solid;
  endtask

  task automatic startRun();
    int base;
    base = int'($urandom_range(0, 3));
    for (int f = 0; f < 8; f++) begin
      framePat[f]   = 2'((base + f) % 4);
      frameSolid[f] = 24'($urandom);
    end
    @(negedge pixclk);
    applyStimulus(framePat[0], frameSolid[0]);
    reset_n     = 1'b1;
    modelActive = 1'b1;
  endtask

  // Reference model: one expected record per clock edge.
  always @(posedge pixclk) begin
    if (!modelActive) k = 0;
    else begin
      k = k + 1;
      sbq.push_back(expectPix(k));
    end
  end

  // Mid-frame the select is scrambled, then set to the next frame's pattern;
  // neither change may disturb the frame in progress.
  always @(negedge pixclk) begin
    int p, phase, f;
    if (modelActive && k >= 2) begin
      p     = k - 2;
      f     = p / FT;
      phase = p % FT;
      if (phase == FT / 4) applyStimulus(2'($urandom), 24'($urandom));
      else if (phase == FT / 2) applyStimulus(framePat[f + 1], frameSolid[f + 1]);
    end
  end

  always @(negedge pixclk) begin
    pix_t want;
    if (sbq.size() > 0) begin
      want = sbq.pop_front();
      checkOutput($sformatf("pixel k=%0d", k), sampleDut(), want);
    end
  end

  initial begin
    $display("[TB] start: raster %0dx%0d, frame %0d cycles", HT, VT, FT);
    repeat (3) @(posedge pixclk);
    #1 checkOutput("reset_state", sampleDut(), expectPix(0));

    startRun();
    while (k < 4 * FT + 25 * HT + 40 + 2) @(negedge pixclk);

    #2 reset_n = 1'b0;
    modelActive = 1'b0;
    #1 checkOutput("async_reset_midframe", sampleDut(), expectPix(0));
    sbq.delete();
    repeat (3) @(posedge pixclk);

    startRun();
    while (k < 3 * FT + 50) @(negedge pixclk);
    #2 modelActive = 1'b0;
    @(negedge pixclk);
    #1 checkValue("scoreboard_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
